// File: rtl/prv664_disp_pkg.sv
// Shared types for the prv664 dispatch stage: FU class numbering, the
// serialisation FSM encoding and the per-lane decoded-instruction view.
package prv664_disp_pkg;

  localparam int DISP_FU_BYPASS = 0;
  localparam int DISP_FU_SYSMAN = 1;
  localparam int DISP_FU_BRU    = 2;
  localparam int DISP_FU_ALU    = 3;
  localparam int DISP_FU_MDIV   = 4;
  localparam int DISP_FU_LSU    = 5;

  localparam int DISP_FU_W   = 3;
  localparam int DISP_ITAG_W = 8;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_DRAIN = 2'd1,
    SER_ISSUE = 2'd2,
    SER_WAIT  = 2'd3
  } ser_state_e;

  typedef struct packed {
    logic                   rs1en;
    logic                   rs2en;
    logic                   rden;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [DISP_FU_W-1:0]   fu;
    logic                   ser;
    logic [DISP_ITAG_W-1:0] itag;
  } disp_lane_t;

  // True when an enabled operand names the given register.
  function automatic logic reg_hit(logic en, logic [4:0] a, logic [4:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/prv664_disp_scoreboard.sv
// Integer scoreboard: per-register busy bit and owning itag, with tagged
// writeback forwarded into the same-cycle view and set-over-clear priority.
module prv664_disp_scoreboard
  import prv664_disp_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int ITAG_W = 8,
  parameter int DISP_W = 2,
  parameter int WB_N   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic [DISP_W-1:0]        set_en_i,
  input  logic [DISP_W*5-1:0]      set_rd_i,
  input  logic [DISP_W*ITAG_W-1:0] set_itag_i,
  input  logic [WB_N-1:0]          wb_valid_i,
  input  logic [WB_N*5-1:0]        wb_rd_i,
  input  logic [WB_N*ITAG_W-1:0]   wb_itag_i,
  output logic [NREG-1:0]          eff_busy_o,
  output logic [NREG-1:0]          busy_o
);

  logic [NREG-1:0]   busy_q, busy_d, clr;
  logic [ITAG_W-1:0] owner_q [NREG];
  logic [ITAG_W-1:0] owner_d [NREG];

  always_comb begin
    clr     = '0;
    busy_d  = '0;
    owner_d = owner_q;
    // A writeback only counts if it carries the tag of the current owner.
    for (int r = 0; r < NREG; r++) begin
      for (int j = 0; j < WB_N; j++) begin
        if (reg_hit(wb_valid_i[j], wb_rd_i[j*5 +: 5], 5'(r)) &&
            wb_itag_i[j*ITAG_W +: ITAG_W] == owner_q[r]) begin
          clr[r] = 1'b1;
        end
      end
    end
    eff_busy_o    = busy_q & ~clr;
    eff_busy_o[0] = 1'b0;
    busy_d        = busy_q & ~clr;
    for (int k = 0; k < DISP_W; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (reg_hit(set_en_i[k], set_rd_i[k*5 +: 5], 5'(r))) begin
          busy_d[r]  = 1'b1;
          owner_d[r] = set_itag_i[k*ITAG_W +: ITAG_W];
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) owner_q[r] <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/prv664_dispatch_nw.sv
// N-lane in-order dispatch: hazard checks against the scoreboard and older
// lanes, per-class FU port arbitration and a drain FSM for CSR/fence ops.
module prv664_dispatch_nw
  import prv664_disp_pkg::*;
#(
  parameter int DISP_W         = 2,
  parameter int NREG           = 32,
  parameter int ITAG_W         = 8,
  parameter int NFU            = 6,
  parameter int WB_N           = 3,
  parameter int SER_LANE0_ONLY = 1,
  localparam int FU_W   = $clog2(NFU),
  localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1,
  localparam int CNT_W  = $clog2(DISP_W + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic [DISP_W-1:0]        in_valid_i,
  input  logic [DISP_W-1:0]        in_rs1en_i,
  input  logic [DISP_W-1:0]        in_rs2en_i,
  input  logic [DISP_W-1:0]        in_rden_i,
  input  logic [DISP_W*5-1:0]      in_rs1_i,
  input  logic [DISP_W*5-1:0]      in_rs2_i,
  input  logic [DISP_W*5-1:0]      in_rd_i,
  input  logic [DISP_W*FU_W-1:0]   in_fu_i,
  input  logic [DISP_W-1:0]        in_ser_i,
  input  logic [DISP_W*ITAG_W-1:0] in_itag_i,
  output logic [CNT_W-1:0]         deq_cnt_o,
  output logic [NFU-1:0]           fu_valid_o,
  input  logic [NFU-1:0]           fu_ready_i,
  output logic [NFU*LANE_W-1:0]    fu_lane_o,
  input  logic [WB_N-1:0]          wb_valid_i,
  input  logic [WB_N*5-1:0]        wb_rd_i,
  input  logic [WB_N*ITAG_W-1:0]   wb_itag_i,
  input  logic                     rob_empty_i,
  output logic [NREG-1:0]          busy_o,
  output logic [1:0]               ser_state_o
);

  disp_lane_t               lane [DISP_W];
  ser_state_e               state_q, state_d;
  logic [NREG-1:0]          eff_busy;
  logic [DISP_W-1:0]        disp, set_en;
  logic [DISP_W*5-1:0]      set_rd;
  logic [DISP_W*ITAG_W-1:0] set_itag;
  logic                     stop, lane_ok;

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      lane[k]       = '0;
      lane[k].rs1en = in_rs1en_i[k];
      lane[k].rs2en = in_rs2en_i[k];
      lane[k].rden  = in_rden_i[k];
      lane[k].rs1   = in_rs1_i[k*5 +: 5];
      lane[k].rs2   = in_rs2_i[k*5 +: 5];
      lane[k].rd    = in_rd_i[k*5 +: 5];
      lane[k].fu    = DISP_FU_W'(in_fu_i[k*FU_W +: FU_W]);
      lane[k].ser   = in_ser_i[k];
      lane[k].itag  = DISP_ITAG_W'(in_itag_i[k*ITAG_W +: ITAG_W]);
    end
  end

  // Handshake: the FU port strobes fu_valid_o with the issuing lane on
  // fu_lane_o; a transfer happens on fu_valid_o & fu_ready_i, and valid is
  // only raised when ready is already high, so every strobe is a transfer.
  always_comb begin
    disp       = '0;
    fu_valid_o = '0;
    fu_lane_o  = '0;
    deq_cnt_o  = '0;
    lane_ok    = 1'b0;
    stop       = flush_i || !rst_n_i || state_q == SER_DRAIN || state_q == SER_WAIT;
    for (int k = 0; k < DISP_W; k++) begin
      lane_ok = !stop && in_valid_i[k];
      if (state_q == SER_ISSUE && k != 0) lane_ok = 1'b0;
      // With SER_LANE0_ONLY clear, younger-lane ser ops are issued unserialised.
      if (state_q == SER_IDLE && lane[k].ser && (k == 0 || SER_LANE0_ONLY != 0)) lane_ok = 1'b0;
      if ((lane[k].rs1en && eff_busy[lane[k].rs1]) ||
          (lane[k].rs2en && eff_busy[lane[k].rs2]) ||
          (lane[k].rden  && eff_busy[lane[k].rd])) lane_ok = 1'b0;
      for (int j = 0; j < DISP_W; j++) begin
        if (j < k && lane[j].rden && lane[j].rd != 5'd0 &&
            (reg_hit(lane[k].rs1en, lane[k].rs1, lane[j].rd) ||
             reg_hit(lane[k].rs2en, lane[k].rs2, lane[j].rd) ||
             reg_hit(lane[k].rden,  lane[k].rd,  lane[j].rd))) lane_ok = 1'b0;
      end
      if (32'(lane[k].fu) >= NFU) lane_ok = 1'b0;
      else if (fu_valid_o[lane[k].fu] || !fu_ready_i[lane[k].fu]) lane_ok = 1'b0;
      if (lane_ok) begin
        disp[k]                                = 1'b1;
        fu_valid_o[lane[k].fu]                 = 1'b1;
        fu_lane_o[lane[k].fu*LANE_W +: LANE_W] = LANE_W'(k);
        deq_cnt_o                              = deq_cnt_o + CNT_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      set_en[k]                      = disp[k] && lane[k].rden && lane[k].rd != 5'd0;
      set_rd[k*5 +: 5]               = lane[k].rd;
      set_itag[k*ITAG_W +: ITAG_W]   = ITAG_W'(lane[k].itag);
    end
  end

  prv664_disp_scoreboard #(
    .NREG   (NREG),
    .ITAG_W (ITAG_W),
    .DISP_W (DISP_W),
    .WB_N   (WB_N)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .set_en_i   (set_en),
    .set_rd_i   (set_rd),
    .set_itag_i (set_itag),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .wb_itag_i  (wb_itag_i),
    .eff_busy_o (eff_busy),
    .busy_o     (busy_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) state_q <= SER_IDLE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (in_valid_i[0] && lane[0].ser) state_d = SER_DRAIN;
      SER_DRAIN: if (busy_o == '0 && rob_empty_i) state_d = SER_ISSUE;
      SER_ISSUE: if (disp[0]) state_d = SER_WAIT;
      SER_WAIT:  if (rob_empty_i) state_d = SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  assign ser_state_o = state_q;

endmodule

// File: doc/prv664_dispatch_nw.md
Name: prv664_dispatch_nw

Overview:
- Parametrised N-lane in-order dispatch stage for the prv664 pipeline. It sits between the decode queue and the function-unit issue ports.
- Owns an internal integer scoreboard: per-register busy bit plus the owning itag. The scoreboard is set at dispatch and cleared by tagged writeback.
- Checks RAW/WAW hazards against the scoreboard and against older lanes in the same cycle.
- Arbitrates lanes onto per-class FU ports and serialises CSR/fence-class instructions through a drain FSM.

Parameters:
- DISP_W, 2, number of decode lanes (lane 0 oldest); 1..4
- NREG, 32, architectural integer registers
- ITAG_W, 8, instruction tag width
- NFU, 6, FU class ports (0 bypass, 1 sysman, 2 bru, 3 alu, 4 mdiv, 5 lsu)
- WB_N, 3, writeback ports clearing the scoreboard
- SER_LANE0_ONLY, 1, serialising instrs are accepted only from lane 0

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset, sampled on rising clk_i
- flush_i  in  1  pipeline flush
- in_valid_i  in  DISP_W  lane holds a decoded instruction
- in_rs1en_i / in_rs2en_i / in_rden_i  in  DISP_W each  operand enables
- in_rs1_i / in_rs2_i / in_rd_i  in  DISP_W*5 each  register indices
- in_fu_i  in  DISP_W*$clog2(NFU)  destination class
- in_ser_i  in  DISP_W  serialising (csr/fence) instruction
- in_itag_i  in  DISP_W*ITAG_W  tags
- deq_cnt_o  out  $clog2(DISP_W+1)  lanes consumed this cycle (always a prefix)
- fu_valid_o  out  NFU  issue strobe per class
- fu_ready_i  in  NFU  FU can accept
- fu_lane_o  out  NFU*$clog2(DISP_W)  lane driving each port
- wb_valid_i  in  WB_N  writeback
- wb_rd_i  in  WB_N*5  writeback register
- wb_itag_i  in  WB_N*ITAG_W  writeback tag
- rob_empty_i  in  1  nothing in flight past dispatch
- busy_o  out  NREG  registered scoreboard busy vector
- ser_state_o  out  2  FSM state, debug

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - busy, owner tags and FSM go to IDLE.
  - All outputs drop to 0 on the same edge.
  - Reset overrides flush and writeback.
- Flush: same effect as reset on the next edge. Combinationally, fu_valid_o=0 and deq_cnt_o=0 in the flush cycle.
- Effective busy(r) = busy[r] & !(any wb_valid_i[j] with wb_rd_i[j]==r and wb_itag_i[j]==owner[r]). Writeback is forwarded into the same-cycle hazard check.
- A writeback whose tag does not match owner[r] is stale and ignored.
- Register x0 is never busy and is never set.
- Lane k dispatches iff all of the following hold:
  - lanes 0..k-1 dispatch, and in_valid_i[k];
  - no effective-busy rs1/rs2/rd (rd checked for WAW);
  - no rs1/rs2/rd match against the rd of any older dispatching lane with rden;
  - FU port in_fu_i[k] is not claimed by an older lane and fu_ready_i is high;
  - the serialisation rules below allow it.
- Dispatch is combinational (0-cycle); deq_cnt_o = count of dispatching lanes.
- Scoreboard update on the clock edge:
  - each dispatching lane with rden and rd!=0 sets busy[rd] and owner[rd]=itag;
  - matching writebacks clear;
  - a set and a clear on the same register in one cycle: set wins.
- Serialisation FSM:
  - IDLE: lane 0 has in_ser_i → it is not dispatched, go to DRAIN. A ser instr in lane k>0 stops dispatch at lane k.
  - DRAIN: nothing dispatches. When busy==0 and rob_empty_i → ISSUE.
  - ISSUE: lane 0 alone may dispatch. On dispatch → WAIT; if not dispatched, stay.
  - WAIT: nothing dispatches. When rob_empty_i → IDLE.
  - Encoding: IDLE=0, DRAIN=1, ISSUE=2, WAIT=3.
- fu_valid_o must never assert for a lane beyond deq_cnt_o. The signal is a valid/ready handshake with the FU: a transfer occurs when fu_valid_o & fu_ready_i.

Decomposition:
- Package prv664_disp_pkg holds:
  - FU class localparams (DISP_FU_*);
  - ser_state_e enum;
  - a lane struct (enables, indices, fu, ser, itag).
- One sub-module, prv664_disp_scoreboard, owns the busy/owner storage, writeback forwarding, and set/clear priority. It exposes eff_busy[NREG] and a busy_o vector.
- Lane arbitration and the FSM stay in the top level.

Test Plan:
- Reset held 2 cycles with in_valid_i=2'b11 → deq_cnt_o=0, fu_valid_o=0, busy_o=0, ser_state_o=0. After release, two independent ALU/BRU instrs → deq_cnt_o=2, busy_o sets rd bits next cycle.
- Lane0 add x5 and lane1 sub x6,x5,x1 → deq_cnt_o=1. Next cycle lane1 moves to lane0 and stalls until wb x5 with the matching itag; it dispatches in that same wb cycle (forwarding).
- x7 owned by itag 0x12; writeback x7 with itag 0x11 → busy[7] stays 1. Writeback with itag 0x12 → clears. Same-cycle dispatch of a new x7 writer plus clear → busy[7]=1, owner = new tag.
- Two lanes both targeting mdiv with fu_ready_i high → only lane 0 issues, deq_cnt_o=1. With fu_ready_i[4]=0 → deq_cnt_o=0.
- csrrw in lane 0 with x3 busy and rob_empty_i=0 → FSM goes 1 and holds. When x3 clears and rob_empty_i=1 → state 2, dispatch, state 3. rob_empty_i=1 → state 0.
- Flush asserted during DRAIN with busy_o=0x000000A0 → next cycle busy_o=0 and ser_state_o=0. Flush plus reset together → reset result.
